// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter in front of the single-port, sync-read RAM.
// Registers the winning command and steers read data back to the port that issued it.
module ram_port_arbiter #(
    parameter int AW        = 8,
    parameter int DW        = 16,
    parameter int FIXED_PRI = 0,
    parameter int MAX_WAIT  = 4
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,

    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,

    output logic          mem_CEB,
    output logic          mem_WEB,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_q
);

    localparam int WCW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(MAX_WAIT);

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    typedef struct packed {
        logic  valid;
        port_e port;
        logic  is_read;
    } ret_t;

    port_e          rr_ptr;
    logic [WCW-1:0] b_wait_cnt;
    ret_t           ret_s1;
    ret_t           ret_s2;
    logic [DW-1:0]  a_rdata_q;
    logic [DW-1:0]  b_rdata_q;

    logic           any_gnt;
    logic           win_we;
    logic [AW-1:0]  win_addr;
    logic [DW-1:0]  win_wdata;

    // rr_ptr names the port favoured when both request; grants are forced low during reset
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (reset) begin
            if (a_req && b_req) begin
                if (FIXED_PRI != 0) begin
                    if ((MAX_WAIT != 0) && (b_wait_cnt == WAIT_LIMIT)) begin
                        b_gnt = 1'b1;
                    end else begin
                        a_gnt = 1'b1;
                    end
                end else if (rr_ptr == PORT_B) begin
                    b_gnt = 1'b1;
                end else begin
                    a_gnt = 1'b1;
                end
            end else begin
                a_gnt = a_req;
                b_gnt = b_req;
            end
        end
    end

    always_comb begin
        any_gnt   = a_gnt | b_gnt;
        win_we    = b_gnt ? b_we    : a_we;
        win_addr  = b_gnt ? b_addr  : a_addr;
        win_wdata = b_gnt ? b_wdata : a_wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_CEB  <= 1'b1;
            mem_WEB  <= 1'b1;
            mem_addr <= '0;
            mem_din  <= '0;
        end else if (any_gnt) begin
            mem_CEB  <= 1'b0;
            mem_WEB  <= ~win_we;
            mem_addr <= win_addr;
            mem_din  <= win_wdata;
        end else begin
            mem_CEB  <= 1'b1;
            mem_WEB  <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr     <= PORT_A;
            b_wait_cnt <= '0;
        end else begin
            if (a_gnt) begin
                rr_ptr <= PORT_B;
            end else if (b_gnt) begin
                rr_ptr <= PORT_A;
            end
            if (!b_req || b_gnt) begin
                b_wait_cnt <= '0;
            end else if (b_wait_cnt != WAIT_LIMIT) begin
                b_wait_cnt <= b_wait_cnt + 1'b1;
            end
        end
    end

    // Return pipe lines up with the RAM: command registered at N, sampled at N+1, data during N+2
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ret_s1 <= '0;
            ret_s2 <= '0;
        end else begin
            ret_s1.valid   <= any_gnt;
            ret_s1.port    <= b_gnt ? PORT_B : PORT_A;
            ret_s1.is_read <= ~win_we;
            ret_s2         <= ret_s1;
        end
    end

    always_comb begin
        a_rvalid = ret_s2.valid & ret_s2.is_read & (ret_s2.port == PORT_A);
        b_rvalid = ret_s2.valid & ret_s2.is_read & (ret_s2.port == PORT_B);
        a_rdata  = a_rvalid ? mem_q : a_rdata_q;
        b_rdata  = b_rvalid ? mem_q : b_rdata_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            if (a_rvalid) begin
                a_rdata_q <= mem_q;
            end
            if (b_rvalid) begin
                b_rdata_q <= mem_q;
            end
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: a round-robin and a fixed-priority instance, each with its own RAM,
// compared cycle by cycle against a rule-level model with a memory array and a return schedule.
module tb_ram_port_arbiter;

    localparam int AW       = 8;
    localparam int DW       = 16;
    localparam int MAX_WAIT = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic          a_req    [2];
    logic          a_we     [2];
    logic [AW-1:0] a_addr   [2];
    logic [DW-1:0] a_wdata  [2];
    logic          a_gnt    [2];
    logic          a_rvalid [2];
    logic [DW-1:0] a_rdata  [2];
    logic          b_req    [2];
    logic          b_we     [2];
    logic [AW-1:0] b_addr   [2];
    logic [DW-1:0] b_wdata  [2];
    logic          b_gnt    [2];
    logic          b_rvalid [2];
    logic [DW-1:0] b_rdata  [2];
    logic          mem_CEB  [2];
    logic          mem_WEB  [2];
    logic [AW-1:0] mem_addr [2];
    logic [DW-1:0] mem_din  [2];
    logic [DW-1:0] mem_q    [2];

    ram_port_arbiter #(.AW(AW), .DW(DW), .FIXED_PRI(0), .MAX_WAIT(MAX_WAIT)) u_rr (
        .clk(clk), .reset(reset),
        .a_req(a_req[0]), .a_we(a_we[0]), .a_addr(a_addr[0]), .a_wdata(a_wdata[0]),
        .a_gnt(a_gnt[0]), .a_rvalid(a_rvalid[0]), .a_rdata(a_rdata[0]),
        .b_req(b_req[0]), .b_we(b_we[0]), .b_addr(b_addr[0]), .b_wdata(b_wdata[0]),
        .b_gnt(b_gnt[0]), .b_rvalid(b_rvalid[0]), .b_rdata(b_rdata[0]),
        .mem_CEB(mem_CEB[0]), .mem_WEB(mem_WEB[0]), .mem_addr(mem_addr[0]),
        .mem_din(mem_din[0]), .mem_q(mem_q[0])
    );

    ram_port_arbiter #(.AW(AW), .DW(DW), .FIXED_PRI(1), .MAX_WAIT(MAX_WAIT)) u_fix (
        .clk(clk), .reset(reset),
        .a_req(a_req[1]), .a_we(a_we[1]), .a_addr(a_addr[1]), .a_wdata(a_wdata[1]),
        .a_gnt(a_gnt[1]), .a_rvalid(a_rvalid[1]), .a_rdata(a_rdata[1]),
        .b_req(b_req[1]), .b_we(b_we[1]), .b_addr(b_addr[1]), .b_wdata(b_wdata[1]),
        .b_gnt(b_gnt[1]), .b_rvalid(b_rvalid[1]), .b_rdata(b_rdata[1]),
        .mem_CEB(mem_CEB[1]), .mem_WEB(mem_WEB[1]), .mem_addr(mem_addr[1]),
        .mem_din(mem_din[1]), .mem_q(mem_q[1])
    );

    // Single-port sync-read RAM behind each instance
    logic [DW-1:0] ram [2][256];
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!mem_CEB[k]) begin
                if (!mem_WEB[k]) ram[k][mem_addr[k]] <= mem_din[k];
                else             mem_q[k] <= ram[k][mem_addr[k]];
            end
        end
    end

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [DW-1:0] mdl_mem      [2][256];
    bit            prio_a       [2];
    int            wait_cnt     [2];
    bit            exp_ceb      [2];
    bit            exp_web      [2];
    logic [AW-1:0] exp_addr     [2];
    logic [DW-1:0] exp_din      [2];
    bit            slot_v       [2][4];
    bit            slot_port    [2][4];
    logic [DW-1:0] slot_data    [2][4];
    logic [DW-1:0] last_a_rdata [2];
    logic [DW-1:0] last_b_rdata [2];
    bit            a_gnt_last   [2];
    bit            b_gnt_last   [2];
    int            obs_a_cnt    [2];
    int            obs_b_cnt    [2];
    int            first_b_cyc  [2];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            prio_a[k]       = 1'b1;
            wait_cnt[k]     = 0;
            exp_ceb[k]      = 1'b1;
            exp_web[k]      = 1'b1;
            exp_addr[k]     = '0;
            exp_din[k]      = '0;
            last_a_rdata[k] = '0;
            last_b_rdata[k] = '0;
            a_gnt_last[k]   = 1'b0;
            b_gnt_last[k]   = 1'b0;
            for (int s = 0; s < 4; s++) slot_v[k][s] = 1'b0;
        end
    endtask

    task automatic idleAll();
        for (int k = 0; k < 2; k++) begin
            a_req[k] = 1'b0; a_we[k] = 1'b0; a_addr[k] = '0; a_wdata[k] = '0;
            b_req[k] = 1'b0; b_we[k] = 1'b0; b_addr[k] = '0; b_wdata[k] = '0;
        end
    endtask

    // A pending, ungranted request is held untouched so the handshake stays legal
    task automatic applyStimulus(input int k, input bit port_b, input bit req, input bit we,
                                 input logic [AW-1:0] addr, input logic [DW-1:0] data);
        if (!port_b) begin
            if (a_req[k] && !a_gnt_last[k]) return;
            a_req[k] = req; a_we[k] = we; a_addr[k] = addr; a_wdata[k] = data;
        end else begin
            if (b_req[k] && !b_gnt_last[k]) return;
            b_req[k] = req; b_we[k] = we; b_addr[k] = addr; b_wdata[k] = data;
        end
    endtask

    // Called at posedge+1 with inputs driven; checks at posedge+4, advances to next posedge+1
    task automatic runCycle();
        bit            ea, eb, wn_we;
        logic [AW-1:0] wn_addr;
        logic [DW-1:0] wn_data;
        int            s;
        #3;
        for (int k = 0; k < 2; k++) begin
            ea = 1'b0;
            eb = 1'b0;
            if (a_req[k] && b_req[k]) begin
                if (k == 1) begin
                    if (wait_cnt[k] == MAX_WAIT) eb = 1'b1;
                    else                         ea = 1'b1;
                end else if (prio_a[k]) ea = 1'b1;
                else                    eb = 1'b1;
            end else begin
                ea = a_req[k];
                eb = b_req[k];
            end
            checkOutput($sformatf("a_gnt[%0d]", k), 32'(a_gnt[k]), 32'(ea));
            checkOutput($sformatf("b_gnt[%0d]", k), 32'(b_gnt[k]), 32'(eb));
            checkOutput($sformatf("mem_CEB[%0d]", k), 32'(mem_CEB[k]), 32'(exp_ceb[k]));
            checkOutput($sformatf("mem_WEB[%0d]", k), 32'(mem_WEB[k]), 32'(exp_web[k]));
            checkOutput($sformatf("mem_addr[%0d]", k), 32'(mem_addr[k]), 32'(exp_addr[k]));
            checkOutput($sformatf("mem_din[%0d]", k), 32'(mem_din[k]), 32'(exp_din[k]));

            s = cyc % 4;
            if (slot_v[k][s]) begin
                if (slot_port[k][s]) last_b_rdata[k] = slot_data[k][s];
                else                 last_a_rdata[k] = slot_data[k][s];
            end
            checkOutput($sformatf("a_rvalid[%0d]", k), 32'(a_rvalid[k]), 32'(slot_v[k][s] && !slot_port[k][s]));
            checkOutput($sformatf("b_rvalid[%0d]", k), 32'(b_rvalid[k]), 32'(slot_v[k][s] && slot_port[k][s]));
            checkOutput($sformatf("a_rdata[%0d]", k), 32'(a_rdata[k]), 32'(last_a_rdata[k]));
            checkOutput($sformatf("b_rdata[%0d]", k), 32'(b_rdata[k]), 32'(last_b_rdata[k]));
            slot_v[k][s] = 1'b0;

            if (a_gnt[k]) obs_a_cnt[k]++;
            if (b_gnt[k]) begin
                obs_b_cnt[k]++;
                if (first_b_cyc[k] < 0) first_b_cyc[k] = cyc;
            end

            if (ea || eb) begin
                wn_we   = eb ? b_we[k]    : a_we[k];
                wn_addr = eb ? b_addr[k]  : a_addr[k];
                wn_data = eb ? b_wdata[k] : a_wdata[k];
                exp_ceb[k]  = 1'b0;
                exp_web[k]  = !wn_we;
                exp_addr[k] = wn_addr;
                exp_din[k]  = wn_data;
                if (wn_we) begin
                    mdl_mem[k][wn_addr] = wn_data;
                end else begin
                    slot_v[k][(cyc + 2) % 4]    = 1'b1;
                    slot_port[k][(cyc + 2) % 4] = eb;
                    slot_data[k][(cyc + 2) % 4] = mdl_mem[k][wn_addr];
                end
            end else begin
                exp_ceb[k] = 1'b1;
                exp_web[k] = 1'b1;
            end
            if (ea)      prio_a[k] = 1'b0;
            else if (eb) prio_a[k] = 1'b1;
            if (b_req[k] && !eb) wait_cnt[k] = (wait_cnt[k] < MAX_WAIT) ? wait_cnt[k] + 1 : wait_cnt[k];
            else                 wait_cnt[k] = 0;
            a_gnt_last[k] = ea;
            b_gnt_last[k] = eb;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t4_start;
        idleAll();
        for (int k = 0; k < 2; k++) begin
            a_req[k] = 1'b1;
            b_req[k] = 1'b1;
        end
        #12;
        for (int k = 0; k < 2; k++) begin
            checkOutput("reset_gnt_a", 32'(a_gnt[k]), 32'd0);
            checkOutput("reset_gnt_b", 32'(b_gnt[k]), 32'd0);
            checkOutput("reset_CEB", 32'(mem_CEB[k]), 32'd1);
            checkOutput("reset_WEB", 32'(mem_WEB[k]), 32'd1);
            checkOutput("reset_addr", 32'(mem_addr[k]), 32'd0);
            checkOutput("reset_din", 32'(mem_din[k]), 32'd0);
            checkOutput("reset_rvalid", 32'(a_rvalid[k] | b_rvalid[k]), 32'd0);
            checkOutput("reset_rdata", 32'(a_rdata[k] | b_rdata[k]), 32'd0);
        end
        @(posedge clk);
        #1;
        idleAll();
        modelReset();
        for (int k = 0; k < 2; k++) first_b_cyc[k] = -1;
        reset = 1'b1;
        $display("[TB] reset released");

        // Fill the working address range through port A
        for (int i = 0; i < 32; i++) begin
            for (int k = 0; k < 2; k++) applyStimulus(k, 1'b0, 1'b1, 1'b1, AW'(i), DW'($urandom));
            runCycle();
        end

        // T6: idle holds address/data, then a lone A request
        for (int k = 0; k < 2; k++) begin
            applyStimulus(k, 1'b0, 1'b0, 1'b0, '0, '0);
            applyStimulus(k, 1'b1, 1'b0, 1'b0, '0, '0);
        end
        repeat (2) runCycle();
        for (int k = 0; k < 2; k++) applyStimulus(k, 1'b0, 1'b1, 1'b1, 8'h07, 16'h1234);
        runCycle();
        for (int k = 0; k < 2; k++) applyStimulus(k, 1'b0, 1'b0, 1'b0, '0, '0);
        runCycle();

        // T2: A writes 0x10, B reads it back the next cycle
        for (int k = 0; k < 2; k++) applyStimulus(k, 1'b0, 1'b1, 1'b1, 8'h10, 16'h00AB);
        runCycle();
        for (int k = 0; k < 2; k++) begin
            applyStimulus(k, 1'b0, 1'b0, 1'b0, '0, '0);
            applyStimulus(k, 1'b1, 1'b1, 1'b0, 8'h10, '0);
        end
        runCycle();
        for (int k = 0; k < 2; k++) applyStimulus(k, 1'b1, 1'b0, 1'b0, '0, '0);
        repeat (2) runCycle();

        // T5: three back-to-back B reads
        for (int i = 1; i <= 3; i++) begin
            for (int k = 0; k < 2; k++) applyStimulus(k, 1'b1, 1'b1, 1'b0, AW'(i), '0);
            runCycle();
        end
        for (int k = 0; k < 2; k++) applyStimulus(k, 1'b1, 1'b0, 1'b0, '0, '0);
        repeat (3) runCycle();

        // T3/T4: both ports requesting continuously
        for (int k = 0; k < 2; k++) begin
            obs_a_cnt[k]   = 0;
            obs_b_cnt[k]   = 0;
            first_b_cyc[k] = -1;
        end
        t4_start = cyc;
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 2; k++) begin
                applyStimulus(k, 1'b0, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), DW'($urandom));
                applyStimulus(k, 1'b1, 1'b1, 1'b0, AW'($urandom_range(0, 31)), '0);
            end
            runCycle();
        end
        checkOutput("rr_a_grants", 32'(obs_a_cnt[0]), 32'd4);
        checkOutput("rr_b_grants", 32'(obs_b_cnt[0]), 32'd4);
        checkOutput("fix_b_forced_cycle", 32'(first_b_cyc[1] - t4_start), 32'd4);
        checkOutput("fix_a_grants", 32'(obs_a_cnt[1]), 32'd7);
        for (int k = 0; k < 2; k++) begin
            applyStimulus(k, 1'b0, 1'b0, 1'b0, '0, '0);
            applyStimulus(k, 1'b1, 1'b0, 1'b0, '0, '0);
        end
        repeat (6) runCycle();

        // Randomised traffic on the shared address range
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < 2; k++) begin
                for (int p = 0; p < 2; p++) begin
                    if ($urandom_range(0, 99) < 60)
                        applyStimulus(k, 1'(p), 1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), DW'($urandom));
                    else
                        applyStimulus(k, 1'(p), 1'b0, 1'b0, '0, '0);
                end
            end
            runCycle();
        end
        for (int k = 0; k < 2; k++) begin
            applyStimulus(k, 1'b0, 1'b0, 1'b0, '0, '0);
            applyStimulus(k, 1'b1, 1'b0, 1'b0, '0, '0);
        end
        repeat (4) runCycle();

        // T1: reset while a read is in flight
        for (int k = 0; k < 2; k++) applyStimulus(k, 1'b0, 1'b1, 1'b0, 8'h05, '0);
        runCycle();
        for (int k = 0; k < 2; k++) applyStimulus(k, 1'b0, 1'b1, 1'b0, 8'h06, '0);
        #2;
        reset = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checkOutput("t1_CEB_in_reset", 32'(mem_CEB[k]), 32'd1);
            checkOutput("t1_gnt_in_reset", 32'(a_gnt[k]), 32'd0);
            checkOutput("t1_rvalid_in_reset", 32'(a_rvalid[k]), 32'd0);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        idleAll();
        modelReset();
        reset = 1'b1;
        repeat (4) runCycle();
        for (int k = 0; k < 2; k++) begin
            obs_a_cnt[k] = 0;
            applyStimulus(k, 1'b0, 1'b1, 1'b0, 8'h02, '0);
            applyStimulus(k, 1'b1, 1'b1, 1'b0, 8'h03, '0);
        end
        runCycle();
        checkOutput("t1_ptr_a_first", 32'(obs_a_cnt[0]), 32'd1);
        for (int k = 0; k < 2; k++) begin
            applyStimulus(k, 1'b0, 1'b0, 1'b0, '0, '0);
            applyStimulus(k, 1'b1, 1'b0, 1'b0, '0, '0);
        end
        repeat (4) runCycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
